lfsr_gen: RTL and testbench

- Parametrised Fibonacci LFSR pseudorandom generator. It replaces the fixed 8-bit LFSR used for random-number generation.
- Adds configurable width, tap mask, reset seed, and multiple shifts per clock.
- Adds runtime enable, runtime seed load, all-zero lockup protection, and a period counter with a wrap pulse.
- Drives random words and bit streams to downstream game/test logic.

---
 rtl/lfsr_gen.sv | 96 +++++++++
 tb/tb_lfsr_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with multi-shift advance, runtime seed load,
// all-zero lockup protection and a period counter that pulses on wrap.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] sr,
    output logic             q,
    output logic             wrap,
    output logic             lock_err,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] start_reg, start_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             wrap_reg, wrap_next;
    logic             lock_err_reg, lock_err_next;

    // stage[k] is the state after k single shifts; stage[STEPS] is the advance result
    logic [WIDTH-1:0] stage [0:STEPS];
    logic [STEPS-1:0] fb;

    assign stage[0] = sr_reg;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_shift
            assign fb[gi]        = ^(stage[gi] & TAPS);
            assign stage[gi + 1] = {stage[gi][WIDTH-2:0], fb[gi]};
        end
    endgenerate

    always_comb begin
        sr_next       = sr_reg;
        start_next    = start_reg;
        cnt_next      = cnt_reg;
        wrap_next     = 1'b0;
        lock_err_next = 1'b0;
        if (load) begin
            if (seed_in == '0) begin
                sr_next       = SEED;
                start_next    = SEED;
                lock_err_next = 1'b1;
            end else begin
                sr_next    = seed_in;
                start_next = seed_in;
            end
            cnt_next = '0;
        end else if (en) begin
            if (sr_reg == '0) begin
                // Defensive recovery: a zero state would otherwise never leave zero
                sr_next       = SEED;
                cnt_next      = '0;
                lock_err_next = 1'b1;
            end else begin
                sr_next = stage[STEPS];
                if (stage[STEPS] == start_reg) begin
                    wrap_next = 1'b1;
                    cnt_next  = '0;
                end else begin
                    cnt_next = cnt_reg + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar) begin
            sr_reg       <= SEED;
            start_reg    <= SEED;
            cnt_reg      <= '0;
            wrap_reg     <= 1'b0;
            lock_err_reg <= 1'b0;
        end else begin
            sr_reg       <= sr_next;
            start_reg    <= start_next;
            cnt_reg      <= cnt_next;
            wrap_reg     <= wrap_next;
            lock_err_reg <= lock_err_next;
        end
    end

    assign sr       = sr_reg;
    assign q        = sr_reg[WIDTH-1];
    assign wrap     = wrap_reg;
    assign lock_err = lock_err_reg;
    assign cnt      = cnt_reg;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed table-driven bench for lfsr_gen: default config, STEPS=4 and a 4-bit variant.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       ar, en, load;
    logic [7:0] seed_in;

    logic [7:0] sr8, cnt8;
    logic       q8, wrap8, lock8;
    logic [7:0] srs, cnts;
    logic       qs, wraps, locks;
    logic [3:0] sr4, cnt4;
    logic       q4, wrap4, lock4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_gen u_d8 (
        .clk(clk), .ar(ar), .en(en), .load(load), .seed_in(seed_in),
        .sr(sr8), .q(q8), .wrap(wrap8), .lock_err(lock8), .cnt(cnt8)
    );

    lfsr_gen #(.STEPS(4)) u_s4 (
        .clk(clk), .ar(ar), .en(en), .load(load), .seed_in(seed_in),
        .sr(srs), .q(qs), .wrap(wraps), .lock_err(locks), .cnt(cnts)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u_w4 (
        .clk(clk), .ar(ar), .en(en), .load(load), .seed_in(seed_in[3:0]),
        .sr(sr4), .q(q4), .wrap(wrap4), .lock_err(lock4), .cnt(cnt4)
    );

    typedef struct {
        logic       ar;
        logic       load;
        logic       en;
        logic [7:0] seed;
        logic [7:0] sr;
        logic [7:0] cnt;
        logic       wrap;
        logic       lock;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic a, input logic l, input logic e, input logic [7:0] s);
        ar      = a;
        load    = l;
        en      = e;
        seed_in = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps_seen;
        ar = 1'b0; en = 1'b0; load = 1'b0; seed_in = 8'h00;

        //           ar load en seed    sr     cnt   wrap lock
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 8'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 8'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h08, 8'd3, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 8'd4, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h23, 8'd5, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'd0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h4A, 8'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h77, 8'h01, 8'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 8'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h04, 8'd2, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'd0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'd0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].ar, tbl[i].load, tbl[i].en, tbl[i].seed);
            $display("vec %0d: ar=%b load=%b en=%b seed=%h -> sr=%h q=%b cnt=%0d wrap=%b lock=%b",
                     i, tbl[i].ar, tbl[i].load, tbl[i].en, tbl[i].seed, sr8, q8, cnt8, wrap8, lock8);
            chk($sformatf("vec%0d_sr", i), 32'(sr8), 32'(tbl[i].sr));
            chk($sformatf("vec%0d_q", i), 32'(q8), 32'(tbl[i].sr[7]));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt8), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap8), 32'(tbl[i].wrap));
            chk($sformatf("vec%0d_lock", i), 32'(lock8), 32'(tbl[i].lock));
        end

        // Full period of the default maximal-length polynomial
        step(1'b1, 1'b0, 1'b0, 8'h00);
        wraps_seen = 0;
        for (int i = 1; i <= 255; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            if (wrap8) wraps_seen++;
            if (i == 255) begin
                $display("period advance %0d: sr=%h cnt=%0d wrap=%b", i, sr8, cnt8, wrap8);
                chk("period_wrap", 32'(wrap8), 32'd1);
                chk("period_sr", 32'(sr8), 32'h01);
                chk("period_cnt", 32'(cnt8), 32'd0);
            end else if (i == 128 || i == 254) begin
                $display("period advance %0d: sr=%h cnt=%0d wrap=%b", i, sr8, cnt8, wrap8);
                chk($sformatf("period_cnt_%0d", i), 32'(cnt8), 32'(i));
            end
        end
        chk("period_wrap_count", 32'(wraps_seen), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("hold after wrap: sr=%h cnt=%0d wrap=%b", sr8, cnt8, wrap8);
        chk("hold_after_wrap", 32'(wrap8), 32'd0);
        chk("hold_after_wrap_sr", 32'(sr8), 32'h01);

        // STEPS=4: one enabled cycle performs four shifts
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        $display("steps4: sr=%h cnt=%0d wrap=%b", srs, cnts, wraps);
        chk("steps4_sr", 32'(srs), 32'h11);
        chk("steps4_cnt", 32'(cnts), 32'd1);
        chk("steps4_q", 32'(qs), 32'd0);

        // 4-bit x^4+x^3+1 variant: wrap every 15 advances
        step(1'b1, 1'b0, 1'b0, 8'h00);
        wraps_seen = 0;
        for (int i = 0; i < 45; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            if (wrap4) wraps_seen++;
            if ((i % 15) == 14) begin
                $display("w4 advance %0d: sr=%h cnt=%0d wrap=%b", i + 1, sr4, cnt4, wrap4);
                chk($sformatf("w4_wrap_%0d", i + 1), 32'(wrap4), 32'd1);
                chk($sformatf("w4_sr_%0d", i + 1), 32'(sr4), 32'h1);
            end
        end
        chk("w4_wrap_count", 32'(wraps_seen), 32'd3);
        chk("w4_lock_idle", 32'(lock4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
